// File: rtl/friscv_token_lut_pkg.sv
// Shared types for the in-order token tracker.
// Holds the per-cycle operation encoding used to update occupancy.
package friscv_token_lut_pkg;

   // Accepted operation for one cycle, after push/pull gating.
   typedef enum logic [1:0] {
      OP_IDLE = 2'b00,
      OP_PUSH = 2'b01,
      OP_PULL = 2'b10,
      OP_BOTH = 2'b11
   } lut_op_t;

   // Folds the two acceptance strobes into a single operation code.
   function automatic lut_op_t decodeOp(input logic pushOk, input logic pullOk);
      return lut_op_t'({pullOk, pushOk});
   endfunction

endpackage

// File: rtl/friscv_token_lut.sv
// In-order token tracker: circular buffer of address tags with a
// combinational "is this tag in flight" seek port and occupancy flags.
// Optional macro FRISCV_LUT_CHECK_EN adds simulation-only misuse messages
// (push while full without pull, pull while empty).
module friscv_token_lut
   import friscv_token_lut_pkg::*;
#(
   parameter int NB_TOKEN = 8,
   parameter int TOKEN_W  = 32
)(
   input  logic               aclk,
   input  logic               srst,
   input  logic               flush,
   input  logic [TOKEN_W-1:0] seek,
   output logic               hit,
   input  logic               push,
   input  logic               pull,
   input  logic [TOKEN_W-1:0] token,
   output logic               full,
   output logic               afull,
   output logic               empty,
   output logic               aempty
);

   localparam int PTR_W = $clog2(NB_TOKEN);
   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(NB_TOKEN);
   localparam logic [CNT_W-1:0] AFULL_CNT = CNT_W'(NB_TOKEN - 1);
   localparam logic [CNT_W-1:0] ZERO_CNT  = '0;
   localparam logic [CNT_W-1:0] ONE_CNT   = CNT_W'(1);

   logic [TOKEN_W-1:0]  r_data [NB_TOKEN];
   logic [NB_TOKEN-1:0] r_valid;
   logic [PTR_W-1:0]    r_wr_ptr;
   logic [PTR_W-1:0]    r_rd_ptr;
   logic [CNT_W-1:0]    r_count;

   logic                w_pull_ok;
   logic                w_push_ok;
   lut_op_t             w_op;
   logic                w_hit;

   // Acceptance: a pull frees a slot in the same cycle, so a push is
   // still taken when full as long as a real pull accompanies it.
   always_comb begin
      w_pull_ok = pull && (r_count != ZERO_CNT);
      w_push_ok = push && ((r_count != FULL_CNT) || w_pull_ok);
      w_op      = decodeOp(w_push_ok, w_pull_ok);
   end

   // Pointer, valid and occupancy state; reset and flush both clear it
   // and flush swallows any push/pull presented alongside it.
   always_ff @(posedge aclk) begin
      if (srst || flush) begin
         r_valid  <= '0;
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         // Clear before set: when full with push+pull both pointers are
         // equal and the slot must end up holding the new token.
         if (w_pull_ok) begin
            r_valid[r_rd_ptr] <= 1'b0;
            r_rd_ptr          <= r_rd_ptr + PTR_W'(1);
         end
         if (w_push_ok) begin
            r_valid[r_wr_ptr] <= 1'b1;
            r_wr_ptr          <= r_wr_ptr + PTR_W'(1);
         end
         case (w_op)
            OP_PUSH: r_count <= r_count + ONE_CNT;
            OP_PULL: r_count <= r_count - ONE_CNT;
            default: r_count <= r_count;
         endcase
      end
   end

   // Token payload storage; left uncleared because the valid bits gate it.
   always_ff @(posedge aclk) begin
      if (!srst && !flush && w_push_ok) begin
         r_data[r_wr_ptr] <= token;
      end
   end

   // Seek match over registered entries only, so same-cycle pushes are
   // not yet visible and same-cycle pulls still match.
   always_comb begin
      w_hit = 1'b0;
      for (int i = 0; i < NB_TOKEN; i++) begin
         if (r_valid[i] && (r_data[i] == seek)) begin
            w_hit = 1'b1;
         end
      end
   end

   assign hit    = w_hit;
   assign full   = (r_count == FULL_CNT);
   assign afull  = (r_count == AFULL_CNT);
   assign empty  = (r_count == ZERO_CNT);
   assign aempty = (r_count == ONE_CNT);

`ifdef FRISCV_LUT_CHECK_EN
   // Simulation-only misuse reporting; has no effect on behaviour.
   always @(posedge aclk) begin
      if (!srst && !flush) begin
         if (push && full && !pull) begin
            $display("ERROR: friscv_token_lut push while full at %t", $realtime);
         end
         if (pull && empty) begin
            $display("ERROR: friscv_token_lut pull while empty at %t", $realtime);
         end
      end
   end
`endif

endmodule

// File: tb/tb_friscv_token_lut.sv
// Scoreboard bench for friscv_token_lut: the stimulus thread queues the
// expected {hit,full,afull,empty,aempty} for each driven cycle and a
// separate monitor pops and compares on the falling edge.
module tb_friscv_token_lut;

   localparam int NB_TOKEN = 8;
   localparam int TOKEN_W  = 32;
   localparam int MAX_CYCLES = 2000;

   typedef struct {
      string    name;
      logic [4:0] exp;
   } exp_t;

   logic               aclk = 1'b0;
   logic               srst = 1'b0;
   logic               flush = 1'b0;
   logic [TOKEN_W-1:0] seek = '0;
   logic               hit;
   logic               push = 1'b0;
   logic               pull = 1'b0;
   logic [TOKEN_W-1:0] token = '0;
   logic               full;
   logic               afull;
   logic               empty;
   logic               aempty;

   exp_t scoreboard[$];
   int   checks = 0;
   int   failures = 0;
   bit   stimDone = 1'b0;

   friscv_token_lut #(
      .NB_TOKEN (NB_TOKEN),
      .TOKEN_W  (TOKEN_W)
   ) dut (
      .aclk   (aclk),
      .srst   (srst),
      .flush  (flush),
      .seek   (seek),
      .hit    (hit),
      .push   (push),
      .pull   (pull),
      .token  (token),
      .full   (full),
      .afull  (afull),
      .empty  (empty),
      .aempty (aempty)
   );

   // Free-running clock, 10 time-unit period.
   always #5 aclk = ~aclk;

   // Drives one cycle's inputs just after the rising edge.
   task automatic applyStimulus(input logic iSrst, input logic iFlush,
                                input logic iPush, input logic iPull,
                                input logic [TOKEN_W-1:0] iToken,
                                input logic [TOKEN_W-1:0] iSeek);
      @(posedge aclk);
      #1;
      srst  = iSrst;
      flush = iFlush;
      push  = iPush;
      pull  = iPull;
      token = iToken;
      seek  = iSeek;
   endtask

   // Queues the expected outputs for the cycle just driven.
   task automatic checkOutput(input string name, input logic eHit,
                              input logic eFull, input logic eAfull,
                              input logic eEmpty, input logic eAempty);
      exp_t e;
      e.name = name;
      e.exp  = {eHit, eFull, eAfull, eEmpty, eAempty};
      scoreboard.push_back(e);
   endtask

   // Monitor: compares every queued expectation against the outputs seen
   // mid-cycle, and ends the run once stimulus is done and the queue drains.
   initial begin : monitor
      int cycles;
      exp_t e;
      logic [4:0] act;
      cycles = 0;
      forever begin
         @(negedge aclk);
         cycles++;
         act = {hit, full, afull, empty, aempty};
         while (scoreboard.size() > 0) begin
            e = scoreboard.pop_front();
            checks++;
            if (act !== e.exp) begin
               failures++;
               $display("[TB] FAIL %s: hit/full/afull/empty/aempty actual=%b required=%b",
                        e.name, act, e.exp);
            end
         end
         if (stimDone) begin
            $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
            $finish;
         end
         if (cycles > MAX_CYCLES) begin
            failures++;
            $display("[TB] FAIL timeout: cycles actual=%0d required<=%0d", cycles, MAX_CYCLES);
            $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
            $finish;
         end
      end
   end

   // Directed stimulus with hand-derived expectations.
   initial begin : stimulus
      // Reset held two cycles, then probe with both extreme seek values.
      applyStimulus(1, 0, 0, 0, 32'h0, 32'h0);
      applyStimulus(1, 0, 0, 0, 32'h0, 32'h0);
      applyStimulus(0, 0, 0, 0, 32'h0, 32'h0);
      checkOutput("reset_seek0", 0, 0, 0, 1, 0);
      applyStimulus(0, 0, 0, 0, 32'h0, 32'hFFFF_FFFF);
      checkOutput("reset_seekF", 0, 0, 0, 1, 0);

      // Single push: invisible in its own cycle, visible next.
      applyStimulus(0, 0, 1, 0, 32'h100, 32'h100);
      checkOutput("push_cycle_nohit", 0, 0, 0, 1, 0);
      applyStimulus(0, 0, 0, 0, 32'h0, 32'h100);
      checkOutput("push_next_hit", 1, 0, 0, 0, 1);
      applyStimulus(0, 0, 0, 0, 32'h0, 32'h104);
      checkOutput("seek_other_miss", 0, 0, 0, 0, 1);
      applyStimulus(0, 1, 0, 0, 32'h0, 32'h100);
      checkOutput("flush_cycle_hit", 1, 0, 0, 0, 1);
      applyStimulus(0, 0, 0, 0, 32'h0, 32'h100);
      checkOutput("after_flush1", 0, 0, 0, 1, 0);

      // Fill with 0..7; flags reflect count before each push.
      for (int k = 0; k < NB_TOKEN; k++) begin
         applyStimulus(0, 0, 1, 0, TOKEN_W'(k), 32'h7);
         checkOutput($sformatf("fill_%0d", k), 0, 1'b0, (k == NB_TOKEN - 1),
                     (k == 0), (k == 1));
      end
      applyStimulus(0, 0, 1, 0, 32'h9, 32'h9);
      checkOutput("push_full_cycle", 0, 1, 0, 0, 0);
      applyStimulus(0, 0, 0, 0, 32'h0, 32'h9);
      checkOutput("push_full_dropped", 0, 1, 0, 0, 0);
      applyStimulus(0, 0, 0, 0, 32'h0, 32'h7);
      checkOutput("full_newest_hit", 1, 1, 0, 0, 0);

      // Pull from full: oldest still hits in the pull cycle.
      applyStimulus(0, 0, 0, 1, 32'h0, 32'h0);
      checkOutput("pull_cycle_hit", 1, 1, 0, 0, 0);
      applyStimulus(0, 0, 0, 0, 32'h0, 32'h0);
      checkOutput("pulled_oldest_miss", 0, 0, 1, 0, 0);
      applyStimulus(0, 0, 0, 0, 32'h0, 32'h1);
      checkOutput("next_oldest_hit", 1, 0, 1, 0, 0);

      // Refill to full, then simultaneous push+pull while full.
      applyStimulus(0, 0, 1, 0, 32'h8, 32'h1);
      checkOutput("refill_cycle", 1, 0, 1, 0, 0);
      applyStimulus(0, 0, 1, 1, 32'hA, 32'hA);
      checkOutput("both_full_cycle", 0, 1, 0, 0, 0);
      applyStimulus(0, 0, 0, 0, 32'h0, 32'hA);
      checkOutput("both_full_new_hit", 1, 1, 0, 0, 0);
      applyStimulus(0, 0, 0, 0, 32'h0, 32'h1);
      checkOutput("both_full_old_miss", 0, 1, 0, 0, 0);
      applyStimulus(0, 0, 0, 0, 32'h0, 32'h2);
      checkOutput("both_full_keep_hit", 1, 1, 0, 0, 0);
      applyStimulus(0, 0, 0, 0, 32'h0, 32'h8);
      checkOutput("both_full_wrap_hit", 1, 1, 0, 0, 0);

      // Flush from full, then pull on empty must not underflow.
      applyStimulus(0, 1, 0, 0, 32'h0, 32'h2);
      checkOutput("flush_full_cycle", 1, 1, 0, 0, 0);
      applyStimulus(0, 0, 0, 1, 32'h0, 32'h2);
      checkOutput("pull_empty_cycle", 0, 0, 0, 1, 0);
      applyStimulus(0, 0, 0, 0, 32'h0, 32'h2);
      checkOutput("pull_empty_after", 0, 0, 0, 1, 0);

      // Push+pull on empty: only the push lands.
      applyStimulus(0, 0, 1, 1, 32'h20, 32'h20);
      checkOutput("both_empty_cycle", 0, 0, 0, 1, 0);
      applyStimulus(0, 0, 1, 0, 32'h21, 32'h20);
      checkOutput("both_empty_push_kept", 1, 0, 0, 0, 1);
      applyStimulus(0, 0, 1, 0, 32'h22, 32'h21);
      checkOutput("count2", 1, 0, 0, 0, 0);

      // Flush with three entries; the push during flush is ignored.
      applyStimulus(0, 1, 1, 0, 32'h23, 32'h22);
      checkOutput("flush3_cycle", 1, 0, 0, 0, 0);
      applyStimulus(0, 0, 0, 0, 32'h0, 32'h23);
      checkOutput("flush_push_ignored", 0, 0, 0, 1, 0);
      applyStimulus(0, 0, 0, 0, 32'h0, 32'h20);
      checkOutput("flush_cleared_20", 0, 0, 0, 1, 0);
      applyStimulus(0, 0, 0, 0, 32'h0, 32'h22);
      checkOutput("flush_cleared_22", 0, 0, 0, 1, 0);

      // Post-flush push starts cleanly from the reset pointers.
      applyStimulus(0, 0, 1, 0, 32'h30, 32'h30);
      checkOutput("post_flush_push", 0, 0, 0, 1, 0);
      applyStimulus(0, 0, 0, 1, 32'h0, 32'h30);
      checkOutput("post_flush_pull_cycle", 1, 0, 0, 0, 1);
      applyStimulus(0, 0, 0, 0, 32'h0, 32'h30);
      checkOutput("post_flush_empty", 0, 0, 0, 1, 0);

      @(posedge aclk);
      #1;
      stimDone = 1'b1;
   end

endmodule

// File: doc/friscv_token_lut.md
Name: friscv_token_lut

Overview:
- Small in-order token tracker used by the memory-ordering logic.
- Each pushed token (an address tag, e.g. a cache-block address) is stored. The oldest token is retired on pull.
- A combinational seek port reports whether any stored token equals a queried value.
- Used in pairs, one per direction, to detect read/write collisions on in-flight requests and report outstanding state.

Parameters:
- NB_TOKEN, 8, number of entries; power of two, >=2.
- TOKEN_W, 32, width of each token in bits.

Ports:
- aclk  input  1  clock; all state updates on rising edge.
- srst  input  1  synchronous, active-high reset.
- flush  input  1  synchronous clear of all entries.
- seek  input  TOKEN_W  value compared against stored tokens.
- hit  output  1  seek matches at least one valid stored entry.
- push  input  1  store token this cycle.
- pull  input  1  retire oldest entry this cycle.
- token  input  TOKEN_W  value written on push.
- full  output  1  count == NB_TOKEN.
- afull  output  1  count == NB_TOKEN-1.
- empty  output  1  count == 0.
- aempty  output  1  count == 1.

Behaviour:
- Storage and pointers:
  - Circular buffer of NB_TOKEN entries, each TOKEN_W data plus one valid bit.
  - Write pointer wr_ptr and read pointer rd_ptr, each $clog2(NB_TOKEN) bits, wrap naturally modulo NB_TOKEN.
  - Occupancy counter count, $clog2(NB_TOKEN)+1 bits, range 0..NB_TOKEN.
- Reset (srst=1, highest priority):
  - All valid bits, pointers and count go to 0.
  - Outputs after reset: empty=1, full=0, afull=0 (1 only if NB_TOKEN-1==0, not allowed), aempty=0, hit=0.
  - Stored data need not be cleared.
- Flush (flush=1, srst=0):
  - Same clearing effect as reset.
  - push and pull in the same cycle are ignored.
- Push:
  - Accepted when push=1 and (count<NB_TOKEN or pull accepted same cycle).
  - Effect: entry[wr_ptr] <= token, valid <= 1, wr_ptr++.
  - Push while full with no pull is dropped; state is unchanged.
- Pull:
  - Accepted when pull=1 and count>0.
  - Effect: valid[rd_ptr] <= 0, rd_ptr++.
  - Pull when empty is ignored; count never underflows.
- Simultaneous push and pull:
  - Both accepted, including when full or when empty. If empty, only the push takes effect.
  - count unchanged when both are accepted, +1 for push only, -1 for pull only.
- hit:
  - Purely combinational: OR over entries of (valid[i] && data[i]==seek).
  - Reflects registered state only. A token pushed this cycle is visible on hit from the next cycle.
  - An entry pulled this cycle still hits during that cycle.
- Status flags: full/afull/empty/aempty are combinational decodes of registered count (zero latency after the edge).
- No backpressure outputs besides full; the caller must not push when full.

Optional Feature:
- FRISCV_LUT_CHECK_EN: when defined, adds simulation-only checks (excluded from synthesis).
  - $display an "ERROR" message with $realtime on push while full without pull.
  - $display an "ERROR" message on pull while empty.
- Undefined: no checking logic; functional behaviour identical.

Decomposition:
- No sub-module; single flat module.
- The count-width expression ($clog2(NB_TOKEN)+1) is computed locally as a localparam.
- Shared constants (opcodes etc.) stay in the existing friscv_h include; nothing new goes there.

Test Plan:
- Reset: assert srst 2 cycles -> empty=1, full=0, aempty=0, afull=0, hit=0 for seek=0 and seek=0xFFFFFFFF.
- Push token=0x100, then seek=0x100 -> hit=0 in push cycle, hit=1 next cycle, aempty=1; seek=0x104 -> hit=0.
- Fill with 8 pushes 0x0..0x7 -> afull=1 after 7th, full=1 after 8th; 9th push 0x9 dropped, seek=0x9 hit=0, count stays 8.
- Pull from full: pull 1 cycle -> entry 0x0 removed (seek=0x0 hit=0), seek=0x1 hit=1, afull=1.
- Simultaneous push 0xA + pull while full -> full stays 1, 0xA hits, oldest token no longer hits.
- Pull on empty -> empty stays 1, no underflow; flush with 3 entries -> empty=1 next cycle, no hits; push during flush ignored.
